// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, 1 or 2 stop bits.
// A one-byte holding register lets the next byte be accepted mid-frame,
// so back-to-back frames leave the line with no idle gap.
//
// Ports:
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   uart_tx_en    byte-valid strobe, accepted when uart_tx_ready is 1
//   uart_tx_data  byte to send, sampled on the accept edge
//   uart_tx_ready holding register empty
//   uart_tx_busy  frame on the line or byte waiting in the holding register
//   uart_txd      TX pin, idles high, driven from a flop
module uart_tx #(
    parameter int BIT_RATE  = 9600,
    parameter int CLK_HZ    = 50000000,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_ready,
    output logic       uart_tx_busy,
    output logic       uart_txd
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    generate
        if (CYCLES_PER_BIT < 2) begin : g_bad_rate
            $error("uart_tx: CLK_HZ / BIT_RATE must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic          stop_cnt, stop_d;
    logic [7:0]    hold_reg, hold_d;
    logic          hold_valid, hold_valid_d;
    logic [7:0]    shift_reg, shift_d;
    logic          txd_d;
    logic          baud_end;

    assign baud_end      = (baud_cnt == BAUD_LAST);
    assign uart_tx_ready = !hold_valid;
    assign uart_tx_busy  = (state != IDLE) | hold_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            uart_txd   <= 1'b1;
        end else begin
            state      <= state_d;
            baud_cnt   <= baud_d;
            bit_idx    <= bit_d;
            stop_cnt   <= stop_d;
            hold_reg   <= hold_d;
            hold_valid <= hold_valid_d;
            shift_reg  <= shift_d;
            uart_txd   <= txd_d;
        end
    end

    always_comb begin
        state_d      = state;
        baud_d       = baud_cnt;
        bit_d        = bit_idx;
        stop_d       = stop_cnt;
        hold_d       = hold_reg;
        hold_valid_d = hold_valid;
        shift_d      = shift_reg;
        txd_d        = uart_txd;

        // Accept never coincides with a hold-to-shift load: the load
        // needs hold_valid, which holds uart_tx_ready low.
        if (uart_tx_en && uart_tx_ready) begin
            hold_d       = uart_tx_data;
            hold_valid_d = 1'b1;
        end

        unique case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (hold_valid) begin
                    shift_d      = hold_reg;
                    hold_valid_d = 1'b0;
                    txd_d        = 1'b0;
                    baud_d       = '0;
                    state_d      = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_reg[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        stop_d  = 1'b0;
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        // The flop drives the bit that will be shift[0]
                        // after this shift.
                        shift_d = shift_reg >> 1;
                        txd_d   = shift_reg[1];
                        bit_d   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (stop_cnt == STOP_LAST) begin
                        if (hold_valid) begin
                            // Next start bit follows with no idle cycle.
                            shift_d      = hold_reg;
                            hold_valid_d = 1'b0;
                            txd_d        = 1'b0;
                            state_d      = START;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
